// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_responder
// Description : CPU read/write request responder backed by an internal
//               synchronous RAM, with programmable wait states.
// Revision    : 1.0 - initial release
// ============================================================================

module cpu_mem_responder #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 8,
    parameter int MEM_DEPTH_LOG2 = 12,
    parameter int WAIT_STATES    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  req_rdwr,
    input  logic                  which_rdwr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdwr_done,
    output logic                  busy,
    output logic                  bus_err
);

    localparam int       c_MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int       c_CNT_W     = 4;
    localparam bit       c_HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [c_CNT_W-1:0] c_WAIT_LOAD =
        c_HAS_WAIT ? c_CNT_W'(WAIT_STATES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [c_CNT_W-1:0]        w_cnt_nxt;
    logic                      r_which;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic                      r_done;
    logic                      r_err;
    logic                      r_busy;
    logic [DATA_WIDTH-1:0]     r_mem [c_MEM_DEPTH];

    logic                      w_latch;
    logic                      w_mem_we;
    logic                      w_rd_load;
    logic                      w_done_nxt;
    logic                      w_err_nxt;
    logic                      w_in_range;
    logic [MEM_DEPTH_LOG2-1:0] w_mem_idx;
    logic [DATA_WIDTH-1:0]     w_rd_val;

    // Range check is over the whole request address; nothing above the RAM
    // is mirrored back into it.
    generate
        if (MEM_DEPTH_LOG2 >= ADDR_WIDTH) begin : g_range_full
            assign w_in_range = 1'b1;
            assign w_mem_idx  = MEM_DEPTH_LOG2'(r_addr);
        end else begin : g_range_part
            assign w_in_range = (r_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2] == '0);
            assign w_mem_idx  = r_addr[MEM_DEPTH_LOG2-1:0];
        end
    endgenerate

    assign w_rd_val = w_in_range ? r_mem[w_mem_idx] : '1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_mem_we    = 1'b0;
        w_rd_load   = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_rdwr) begin
                    w_latch = 1'b1;
                    if (c_HAS_WAIT) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = c_WAIT_LOAD;
                    end else begin
                        w_state_nxt = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_ACCESS;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_ACCESS: begin
                w_mem_we    = r_which & w_in_range;
                w_rd_load   = ~r_which;
                w_done_nxt  = 1'b1;
                w_err_nxt   = ~w_in_range;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_which <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else if (enable) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            if (w_latch) begin
                r_which <= which_rdwr;
                r_addr  <= addr;
                r_wdata <= wdata;
            end
            if (w_rd_load) begin
                r_rdata <= w_rd_val;
            end
        end
    end

    // RAM contents survive reset; a reset edge still blocks a pending write.
    always_ff @(posedge clk) begin
        if (!rst && enable && w_mem_we) begin
            r_mem[w_mem_idx] <= r_wdata;
        end
    end

    assign rdata     = r_rdata;
    assign rdwr_done = r_done;
    assign busy      = r_busy;
    assign bus_err   = r_err;

endmodule

`default_nettype wire
